usart_baud_gen: RTL and testbench

Parametrised baud-rate generator for the USART, successor to the single-rate prescaler. It produces the RX oversampling strobe, the RX mid-bit strobe, and the TX bit strobe, plus the XCK clock for synchronous master mode. It supports normal (×16) and double-speed (×8) asynchronous oversampling and RX phase realignment on start-bit detection. It sits between the USART control registers and the RX/TX shift engines.

---
 rtl/usart_baud_gen_if.sv | 24 ++
 rtl/usart_baud_gen.sv | 61 ++++++
 tb/tb_usart_baud_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/usart_baud_gen_if.sv
// usart_baud_gen_if: configuration inputs and strobe outputs of the USART baud generator
interface usart_baud_gen_if #(parameter int BSEL_W = 12);
  logic [BSEL_W-1:0] bsel;
  logic              u2x;
  logic              umsel;
  logic              change_cfg;
  logic              rxen;
  logic              txen;
  logic              rx_restart;
  logic              clr_tx_cnt;
  logic              rx_smp_en;
  logic [3:0]        rx_smp_idx;
  logic              rx_bit_en;
  logic              tx_bit_en;
  logic              xck_o;
  modport master (
    output bsel, u2x, umsel, change_cfg, rxen, txen, rx_restart, clr_tx_cnt,
    input  rx_smp_en, rx_smp_idx, rx_bit_en, tx_bit_en, xck_o
  );
  modport slave (
    input  bsel, u2x, umsel, change_cfg, rxen, txen, rx_restart, clr_tx_cnt,
    output rx_smp_en, rx_smp_idx, rx_bit_en, tx_bit_en, xck_o
  );
endinterface

// File: rtl/usart_baud_gen.sv
// usart_baud_gen: RX/TX prescalers, oversampling strobes and synchronous-master XCK
module usart_baud_gen #(
  parameter int BSEL_W   = 12,
  parameter bit SYNC_RST = 1'b0
) (
  input logic             clk,
  input logic             nrst,
  usart_baud_gen_if.slave bus
);
  logic [BSEL_W-1:0] r_rx_prsc, r_tx_prsc;
  logic [3:0]        r_rx_idx, r_tx_cnt;
  logic              r_xck;
  logic [3:0]        w_ovs_max, w_mid;
  logic              w_x8, w_tx_act, w_rx_rst, w_rx_tick, w_tx_tick, w_rx_smp;
  // Only the asynchronous-reset variant exists; the parameter is kept for interface compatibility.
  if (SYNC_RST) begin : g_sync_rst_reserved
  end
  // Expiry qualification and strobe generation; strobes are gated by nrst so they stay 0 in reset.
  always_comb begin
    w_x8           = bus.u2x & ~bus.umsel;
    w_ovs_max      = w_x8 ? 4'd7 : 4'd15;
    w_mid          = w_x8 ? 4'd3 : 4'd7;
    w_tx_act       = bus.umsel ? (bus.txen | bus.rxen) : bus.txen;
    w_rx_rst       = bus.rx_restart & ~bus.umsel;
    w_rx_tick      = nrst & bus.rxen & (r_rx_prsc == '0) & ~bus.change_cfg & ~w_rx_rst;
    w_tx_tick      = nrst & w_tx_act & (r_tx_prsc == '0) & ~bus.change_cfg & ~bus.clr_tx_cnt;
    w_rx_smp       = bus.umsel ? (bus.rxen & w_tx_tick & ~r_xck) : w_rx_tick;
    bus.rx_smp_en  = w_rx_smp;
    bus.rx_bit_en  = bus.umsel ? w_rx_smp : (w_rx_tick & (r_rx_idx == w_mid));
    bus.tx_bit_en  = bus.txen & w_tx_tick & (bus.umsel ? r_xck : (r_tx_cnt == w_ovs_max));
    bus.rx_smp_idx = r_rx_idx;
    bus.xck_o      = r_xck;
  end
  // RX prescaler: reload on config change, realignment, expiry or while disabled, else count down.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_rx_prsc <= '0;
    else r_rx_prsc <= (bus.change_cfg | w_rx_rst | ~bus.rxen | (r_rx_prsc == '0)) ? bus.bsel : r_rx_prsc - BSEL_W'(1);
  end
  // TX prescaler: also the XCK time base, so in master mode it runs whenever either side is enabled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_tx_prsc <= '0;
    else r_tx_prsc <= (bus.change_cfg | bus.clr_tx_cnt | ~w_tx_act | (r_tx_prsc == '0)) ? bus.bsel : r_tx_prsc - BSEL_W'(1);
  end
  // RX sample index: advances per sample and wraps at OVS-1; held at 0 in master mode.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_rx_idx <= '0;
    else if (bus.change_cfg | w_rx_rst | ~bus.rxen | bus.umsel) r_rx_idx <= '0;
    else if (w_rx_tick) r_rx_idx <= (r_rx_idx == w_ovs_max) ? 4'd0 : r_rx_idx + 4'd1;
  end
  // TX oversample counter (async) and XCK toggle (master) share the TX prescaler expiry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_cnt <= '0;
      r_xck    <= 1'b0;
    end else begin
      r_tx_cnt <= (bus.change_cfg | bus.clr_tx_cnt | ~bus.txen | bus.umsel) ? 4'd0 :
                  w_tx_tick ? ((r_tx_cnt == w_ovs_max) ? 4'd0 : r_tx_cnt + 4'd1) : r_tx_cnt;
      r_xck    <= (bus.change_cfg | ~bus.umsel | ~(bus.txen | bus.rxen)) ? 1'b0 : r_xck ^ w_tx_tick;
    end
  end
endmodule

// File: tb/tb_usart_baud_gen.sv
// tb_usart_baud_gen: scoreboard bench; stimulus queues expected strobe cycles, a monitor pops and compares
module tb_usart_baud_gen;
  typedef struct { int cyc; int idx; } ev_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic prev_xck = 1'b0;
  ev_t  q_smp[$];
  int   q_rbit[$], q_tx[$], q_xr[$], q_xf[$];

  usart_baud_gen_if #(.BSEL_W(12)) bus ();
  usart_baud_gen #(.BSEL_W(12), .SYNC_RST(1'b0)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string ph);
    chk({ph, " leftover expected events"}, q_smp.size() + q_rbit.size() + q_tx.size() + q_xr.size() + q_xf.size(), 0);
    q_smp.delete(); q_rbit.delete(); q_tx.delete(); q_xr.delete(); q_xf.delete();
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, " rx_smp_en"}, int'(bus.rx_smp_en), 0);
    chk({ph, " rx_smp_idx"}, int'(bus.rx_smp_idx), 0);
    chk({ph, " rx_bit_en"}, int'(bus.rx_bit_en), 0);
    chk({ph, " tx_bit_en"}, int'(bus.tx_bit_en), 0);
    chk({ph, " xck_o"}, int'(bus.xck_o), 0);
  endtask

  // Monitor: each observed strobe or XCK edge must match the next queued cycle (-1 = nothing queued)
  always @(negedge clk) begin
    ev_t e;
    int  x;
    if (mon_en) begin
      if (bus.rx_smp_en) begin
        e = '{-1, -1};
        if (q_smp.size() != 0) e = q_smp.pop_front();
        chk("rx_smp_en cycle", cyc, e.cyc);
        chk("rx_smp_idx", int'(bus.rx_smp_idx), e.idx);
      end
      if (bus.rx_bit_en) begin
        x = (q_rbit.size() != 0) ? q_rbit.pop_front() : -1;
        chk("rx_bit_en cycle", cyc, x);
      end
      if (bus.tx_bit_en) begin
        x = (q_tx.size() != 0) ? q_tx.pop_front() : -1;
        chk("tx_bit_en cycle", cyc, x);
      end
      if (bus.xck_o && !prev_xck) begin
        x = (q_xr.size() != 0) ? q_xr.pop_front() : -1;
        chk("xck_o rise cycle", cyc, x);
      end
      if (!bus.xck_o && prev_xck) begin
        x = (q_xf.size() != 0) ? q_xf.pop_front() : -1;
        chk("xck_o fall cycle", cyc, x);
      end
    end
    prev_xck = bus.xck_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c, t, m, s, r, n;
    bus.bsel = 12'd3; bus.u2x = 0; bus.umsel = 0; bus.change_cfg = 0;
    bus.rxen = 1; bus.txen = 1; bus.rx_restart = 0; bus.clr_tx_cnt = 0;
    // Reset with both enables high: every output must stay 0
    go_to(3);
    chk_zero("reset");
    // Async x16, bsel=3: samples every 4, mid-bit at idx 7, TX bit every 64
    t0 = cyc;
    for (int k = 0; k <= 32; k++) q_smp.push_back('{t0 + 4*k, k % 16});
    q_rbit.push_back(t0 + 28); q_rbit.push_back(t0 + 92);
    q_tx.push_back(t0 + 60);   q_tx.push_back(t0 + 124);
    nrst = 1; mon_en = 1;
    go_to(t0 + 130);
    drain("async x16");
    // u2x=1 via change_cfg (also lands on an expiry, which must be suppressed)
    c = cyc;
    bus.change_cfg = 1; bus.u2x = 1;
    for (int k = 0; k <= 23; k++) q_smp.push_back('{c + 4*(k+1), k % 8});
    q_rbit.push_back(c + 16); q_rbit.push_back(c + 48); q_rbit.push_back(c + 80);
    q_tx.push_back(c + 32);   q_tx.push_back(c + 64);   q_tx.push_back(c + 96);
    go_to(c + 1); bus.change_cfg = 0;
    go_to(c + 100);
    drain("async x8");
    // rx_restart realignment with bsel=9, then a restart coincident with an expiry
    c = cyc; t = c + 25;
    bus.change_cfg = 1; bus.u2x = 0; bus.bsel = 12'd9;
    q_smp.push_back('{c + 10, 0}); q_smp.push_back('{c + 20, 1});
    for (int k = 1; k <= 8; k++) q_smp.push_back('{t + 10*k, k - 1});
    q_smp.push_back('{t + 100, 0});
    q_rbit.push_back(t + 80);
    go_to(c + 1); bus.change_cfg = 0;
    go_to(t); bus.rx_restart = 1;
    go_to(t + 1); bus.rx_restart = 0;
    chk("rx_smp_idx after restart", int'(bus.rx_smp_idx), 0);
    go_to(t + 90); bus.rx_restart = 1;
    go_to(t + 91); bus.rx_restart = 0;
    go_to(t + 101);
    drain("rx_restart");
    // change_cfg mid-bit with bsel 3 -> 0: divide-by-1 afterwards
    c = cyc; m = c + 8;
    bus.change_cfg = 1; bus.bsel = 12'd3;
    q_smp.push_back('{c + 4, 0});
    for (int k = 0; k <= 33; k++) q_smp.push_back('{m + 1 + k, k % 16});
    q_rbit.push_back(m + 8); q_rbit.push_back(m + 24);
    q_tx.push_back(m + 16);  q_tx.push_back(m + 32);
    go_to(c + 1); bus.change_cfg = 0;
    go_to(m); bus.change_cfg = 1; bus.bsel = 12'd0;
    go_to(m + 1); bus.change_cfg = 0;
    go_to(m + 35);
    drain("bsel 0");
    // Synchronous master, bsel=3: XCK period 8, RX strobes on rising, TX on falling toggle
    s = cyc;
    bus.change_cfg = 1; bus.umsel = 1; bus.bsel = 12'd3;
    for (int k = 0; k <= 4; k++) begin
      q_smp.push_back('{s + 4 + 8*k, 0});
      q_rbit.push_back(s + 4 + 8*k);
      q_xr.push_back(s + 5 + 8*k);
    end
    for (int k = 0; k <= 3; k++) begin
      q_tx.push_back(s + 8 + 8*k);
      q_xf.push_back(s + 9 + 8*k);
    end
    q_xf.push_back(s + 41);
    go_to(s + 1); bus.change_cfg = 0;
    go_to(s + 40);
    chk("xck_o high before disable", int'(bus.xck_o), 1);
    bus.txen = 0; bus.rxen = 0;
    go_to(s + 41);
    chk("xck_o after disable", int'(bus.xck_o), 0);
    go_to(s + 45);
    drain("sync master");
    // Asynchronous reset mid-frame, then first sample right after release
    r = cyc;
    bus.change_cfg = 1; bus.umsel = 0; bus.rxen = 1; bus.txen = 1;
    q_smp.push_back('{r + 4, 0}); q_smp.push_back('{r + 8, 1});
    go_to(r + 1); bus.change_cfg = 0;
    go_to(r + 10);
    nrst = 0;
    #1;
    chk_zero("async reset");
    go_to(r + 12);
    n = cyc;
    q_smp.push_back('{n, 0}); q_smp.push_back('{n + 4, 1}); q_smp.push_back('{n + 8, 2});
    nrst = 1;
    go_to(n + 10);
    drain("reset release");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
